// File: rtl/uart_time_reporter.sv
// Snapshots hour/min/sec on each accepted 1 Hz tick and sends "HH:MM:SS\r\n"
// as 8N1 UART characters, LSB first, on a registered TX pin.
module uart_time_reporter #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz_en,
    input  logic       report_en,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      idx_q, idx_d;
    logic [4:0]      hour_q, hour_d;
    logic [5:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;

    logic [5:0]      fld;
    logic            fld_ok;
    logic [3:0]      tens, ones;
    logic [7:0]      char_byte;
    logic            bit_end;

    // Character for the current index, built from the frozen snapshot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fld       = '0;
        fld_ok    = 1'b1;
        char_byte = 8'h3A;
        case (idx_q)
            4'd0, 4'd1: begin fld = {1'b0, hour_q}; fld_ok = (hour_q <= 5'd23); end
            4'd3, 4'd4: begin fld = min_q;          fld_ok = (min_q  <= 6'd59); end
            4'd6, 4'd7: begin fld = sec_q;          fld_ok = (sec_q  <= 6'd59); end
            default: ;
        endcase
        tens = 4'(fld / 6'd10);
        ones = 4'(fld % 6'd10);
        case (idx_q)
            4'd0, 4'd3, 4'd6: char_byte = fld_ok ? (8'h30 + {4'h0, tens}) : 8'h2D;
            4'd1, 4'd4, 4'd7: char_byte = fld_ok ? (8'h30 + {4'h0, ones}) : 8'h2D;
            4'd8:             char_byte = 8'h0D;
            4'd9:             char_byte = 8'h0A;
            default:          char_byte = 8'h3A;
        endcase
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        idx_d     = idx_q;
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        overrun_d = overrun_q | (clk_1hz_en & busy_q);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (clk_1hz_en && report_en && !busy_q) begin
                    state_d = S_START;
                    idx_d   = '0;
                    hour_d  = hour;
                    min_d   = min;
                    sec_d   = sec;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 4'd9) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_START;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the pins are plain flops.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = char_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            hour_q    <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Scoreboard bench: ticks push expected ASCII bytes; a mid-bit UART monitor
// decodes tx and compares each received character against the queue.
module tb_uart_time_reporter;

    localparam int DIV  = 16;
    localparam int LINE = 100 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_1hz_en;
    logic       report_en;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       tx;
    logic       busy;
    logic       overrun;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      line_end = 0;
    logic        exp_ovr = 1'b0;
    logic [7:0]  exp_q[$];

    uart_time_reporter #(.CLK_FREQ(160), .BAUD(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_1hz_en (clk_1hz_en),
        .report_en  (report_en),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .tx         (tx),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference formatting: two decimal digits per field, "--" when out of range.
    function automatic void push_field(input int v, input int lim);
        if (v > lim) begin
            exp_q.push_back(8'h2D);
            exp_q.push_back(8'h2D);
        end else begin
            exp_q.push_back(8'(48 + v / 10));
            exp_q.push_back(8'(48 + v % 10));
        end
    endfunction

    function automatic void push_line(input int h, input int m, input int s);
        push_field(h, 23);
        exp_q.push_back(8'h3A);
        push_field(m, 59);
        exp_q.push_back(8'h3A);
        push_field(s, 59);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // All main-thread code runs 1 time unit after a rising edge.
    task automatic wait_edge(input longint n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        longint e;
        bit     acc;
        bit     drop;
        clk_1hz_en = 1'b1;
        @(posedge clk);
        #1;
        clk_1hz_en = 1'b0;
        e    = cyc;
        drop = (e <= line_end);
        acc  = report_en && !drop;
        if (drop) exp_ovr = 1'b1;
        if (acc) begin
            line_end = e + LINE;
            push_line(int'(hour), int'(min), int'(sec));
            check("start_tx_low", tx, 1'b0);
            check("start_busy", busy, 1'b1);
        end else begin
            check("ignored_busy", busy, (e < line_end) ? 1 : 0);
            if (!drop) check("ignored_tx", tx, 1'b1);
        end
        check("overrun", overrun, exp_ovr);
    endtask

    task automatic wait_idle();
        wait_edge(line_end + 4);
        check("idle_busy", busy, 1'b0);
        check("idle_tx", tx, 1'b1);
        check("pending_bytes", exp_q.size(), 0);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour = 5'(h);
        min  = 6'(m);
        sec  = 6'(s);
    endtask

    // UART monitor: start detected at the first falling-edge sample with tx=0,
    // then every bit is sampled in its middle.
    initial begin
        bit         mon_on = 1'b0;
        int         mon_cnt = 0;
        logic [7:0] mon_byte = '0;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_on = 1'b0;
            end else if (!mon_on) begin
                if (tx === 1'b0) begin
                    mon_on  = 1'b1;
                    mon_cnt = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == 8) begin
                    check("start_bit", tx, 1'b0);
                end else if (mon_cnt > 8 && mon_cnt < 152 && (mon_cnt - 8) % 16 == 0) begin
                    mon_byte[(mon_cnt - 8) / 16 - 1] = tx;
                end else if (mon_cnt == 152) begin
                    check("stop_bit", tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", mon_byte);
                    end else begin
                        want = exp_q.pop_front();
                        check("rx_byte", mon_byte, want);
                    end
                    mon_on = 1'b0;
                end
            end
        end
    end

    initial begin
        longint e;
        rst        = 1'b1;
        clk_1hz_en = 1'b0;
        report_en  = 1'b1;
        set_time(0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overrun", overrun, 1'b0);

        // Ticks with reporting disabled do nothing.
        report_en = 1'b0;
        repeat (3) begin
            wait_edge(cyc + 20);
            tick();
        end
        report_en = 1'b1;
        wait_edge(cyc + 5);

        // Nominal line and exact busy length.
        set_time(12, 34, 56);
        tick();
        e = cyc;
        wait_edge(e + LINE - 1);
        check("busy_last_cycle", busy, 1'b1);
        @(posedge clk);
        #1;
        check("busy_fall", busy, 1'b0);
        check("busy_fall_tx", tx, 1'b1);
        wait_idle();

        set_time(23, 59, 59);
        tick();
        wait_idle();
        set_time(0, 0, 0);
        tick();
        wait_idle();

        // Snapshot: inputs churn while the line is in flight.
        set_time(9, 5, 41);
        tick();
        repeat (6) begin
            wait_edge(cyc + 200);
            set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        end
        wait_idle();

        set_time(24, 60, 7);
        tick();
        wait_idle();

        // Random fields, including out-of-range values.
        repeat (5) begin
            set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            wait_edge(cyc + $urandom_range(1, 30));
            tick();
            wait_idle();
        end

        // report_en dropped mid-line: the line finishes, later ticks are ignored.
        set_time(17, 2, 33);
        tick();
        wait_edge(cyc + 300);
        report_en = 1'b0;
        wait_idle();
        tick();
        wait_edge(cyc + 50);
        check("no_new_line", busy, 1'b0);
        report_en = 1'b1;

        // Overrun: tick 500 cycles in is dropped, then the boundary pair.
        set_time(8, 15, 22);
        tick();
        e = cyc;
        set_time(1, 1, 1);
        wait_edge(e + 499);
        tick();
        wait_edge(line_end - 1);
        set_time(3, 4, 5);
        tick();
        tick();
        wait_idle();
        check("overrun_sticky", overrun, 1'b1);

        // Asynchronous reset during DATA of character 4.
        set_time(7, 8, 9);
        tick();
        e = cyc;
        wait_edge(e + 4 * 10 * DIV + 50);
        #1 rst = 1'b1;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_overrun", overrun, 1'b0);
        exp_q.delete();
        line_end = 0;
        exp_ovr  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_edge(cyc + 5);
        set_time(19, 45, 30);
        tick();
        wait_idle();
        check("final_overrun", overrun, exp_ovr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
